// File: rtl/mem_dump_uart_if.sv
// Bus bundle between the memory dump engine and its surroundings.
//   master : host/system side (drives start request, flow control, read data)
//   slave  : dump engine side (drives address, read strobe, serial line, status)
// Signals:
//   start, start_adr[20:0], count[21:0] : dump request and its range
//   tx_hold                             : host flow control, high = pause at byte boundary
//   adr[20:0], read, din[7:0]           : external memory read port
//   tx                                  : UART serial output, idle high
//   busy, done                          : dump status
interface mem_dump_uart_if;
  logic        start;
  logic [20:0] start_adr;
  logic [21:0] count;
  logic        tx_hold;
  logic [20:0] adr;
  logic        read;
  logic [7:0]  din;
  logic        tx;
  logic        busy;
  logic        done;

  modport master (
    output start, start_adr, count, tx_hold, din,
    input  adr, read, tx, busy, done
  );

  modport slave (
    input  start, start_adr, count, tx_hold, din,
    output adr, read, tx, busy, done
  );
endinterface

// File: rtl/mem_dump_uart.sv
// Streams a range of the 21-bit external memory out over UART TX (8N1),
// one byte at a time, optionally followed by a mod-256 checksum frame.
// Ports:
//   clk      : single clock, all outputs are registered or decoded from registers
//   n_reset  : asynchronous active-low reset, aborts any frame in progress
//   bus      : mem_dump_uart_if.slave (request, flow control, memory port, tx, status)
// Parameters:
//   CLK_DIV  : clk cycles per UART bit (4..4095)
//   READ_LAT : cycles read stays high before din is captured (1..7)
//   SEND_SUM : 1 appends the checksum frame after the last data byte
module mem_dump_uart #(
  parameter int CLK_DIV  = 104,
  parameter int READ_LAT = 2,
  parameter int SEND_SUM = 1
) (
  input  logic             clk,
  input  logic             n_reset,
  mem_dump_uart_if.slave   bus
);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_SEND, S_SUM, S_FIN} state_t;

  localparam logic [2:0]  LAT_LAST = 3'(READ_LAT - 1);
  localparam logic [11:0] DIV_LAST = 12'(CLK_DIV - 1);

  state_t      state_reg, state_next;
  logic [20:0] adr_reg, adr_next;
  logic [21:0] rem_reg, rem_next;
  logic [7:0]  sum_reg, sum_next;
  logic [7:0]  shift_reg, shift_next;
  logic        read_reg, read_next;
  logic        tx_reg, tx_next;
  logic [2:0]  lat_reg, lat_next;
  logic [11:0] div_reg, div_next;
  logic [3:0]  bit_reg, bit_next;
  logic        is_sum_reg, is_sum_next;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_reg  <= S_IDLE;
      adr_reg    <= '0;
      rem_reg    <= '0;
      sum_reg    <= '0;
      shift_reg  <= '0;
      read_reg   <= 1'b0;
      tx_reg     <= 1'b1;
      lat_reg    <= '0;
      div_reg    <= '0;
      bit_reg    <= '0;
      is_sum_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      adr_reg    <= adr_next;
      rem_reg    <= rem_next;
      sum_reg    <= sum_next;
      shift_reg  <= shift_next;
      read_reg   <= read_next;
      tx_reg     <= tx_next;
      lat_reg    <= lat_next;
      div_reg    <= div_next;
      bit_reg    <= bit_next;
      is_sum_reg <= is_sum_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    adr_next    = adr_reg;
    rem_next    = rem_reg;
    sum_next    = sum_reg;
    shift_next  = shift_reg;
    read_next   = read_reg;
    tx_next     = tx_reg;
    lat_next    = lat_reg;
    div_next    = div_reg;
    bit_next    = bit_reg;
    is_sum_next = is_sum_reg;

    case (state_reg)
      S_IDLE: begin
        if (bus.start) begin
          adr_next    = bus.start_adr;
          rem_next    = bus.count;
          sum_next    = '0;
          lat_next    = '0;
          is_sum_next = 1'b0;
          // The first read can start right away if nothing holds it back;
          // an empty dump still spends one busy cycle in READ.
          read_next   = (bus.count != 22'd0) && !bus.tx_hold;
          state_next  = S_READ;
        end
      end

      S_READ: begin
        if (read_reg) begin
          if (lat_reg == LAT_LAST) begin
            // Capture edge: data latched, start bit goes out next cycle.
            shift_next = bus.din;
            sum_next   = sum_reg + bus.din;
            adr_next   = adr_reg + 21'd1;
            rem_next   = rem_reg - 22'd1;
            read_next  = 1'b0;
            lat_next   = '0;
            tx_next    = 1'b0;
            div_next   = '0;
            bit_next   = '0;
            state_next = S_SEND;
          end else begin
            lat_next = lat_reg + 3'd1;
          end
        end else if (rem_reg == 22'd0) begin
          state_next = (SEND_SUM != 0) ? S_SUM : S_FIN;
        end else if (!bus.tx_hold) begin
          read_next = 1'b1;
        end
      end

      S_SEND: begin
        if (div_reg == DIV_LAST) begin
          div_next = '0;
          if (bit_reg == 4'd9) begin
            // End of stop bit: the byte boundary where tx_hold is honoured.
            tx_next  = 1'b1;
            bit_next = '0;
            lat_next = '0;
            if (is_sum_reg) begin
              state_next = S_FIN;
            end else if (rem_reg != 22'd0) begin
              read_next  = !bus.tx_hold;
              state_next = S_READ;
            end else begin
              state_next = (SEND_SUM != 0) ? S_SUM : S_FIN;
            end
          end else begin
            // bit_reg is the bit just finished: 0 start, 1..8 data, 9 stop.
            bit_next = bit_reg + 4'd1;
            tx_next  = (bit_reg == 4'd8) ? 1'b1 : shift_reg[bit_reg[2:0]];
          end
        end else begin
          div_next = div_reg + 12'd1;
        end
      end

      S_SUM: begin
        if (!bus.tx_hold) begin
          shift_next  = sum_reg;
          is_sum_next = 1'b1;
          tx_next     = 1'b0;
          div_next    = '0;
          bit_next    = '0;
          state_next  = S_SEND;
        end
      end

      S_FIN: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign bus.adr  = adr_reg;
  assign bus.read = read_reg;
  assign bus.tx   = tx_reg;
  assign bus.busy = (state_reg == S_READ) || (state_reg == S_SEND) || (state_reg == S_SUM);
  assign bus.done = (state_reg == S_FIN);

endmodule
